univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal register: a WIDTH-bit bank of D flip-flops with true and complement outputs, plus synchronous hold, parallel load, shift, rotate, clear and complement modes. It is the multi-bit successor to the team's single-bit D flip-flop. It adds an asynchronous reset and a shift counter that flags each completed full-word serial transfer. It sits between serial links and parallel datapaths: serial-to-parallel capture, parallel-to-serial launch, and barrel-free rotate.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, 0 (WIDTH bits), value loaded into q on reset.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  operation enable; 0 forces hold
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  parallel load data
- sin_lsb  input  1  serial bit entering bit 0 on shift-left
- sin_msb  input  1  serial bit entering bit WIDTH-1 on shift-right
- q  output  WIDTH  register contents
- q_bar  output  WIDTH  bitwise complement of q, combinational from q
- so_msb  output  1  q[WIDTH-1], combinational
- so_lsb  output  1  q[0], combinational
- word_done  output  1  registered one-cycle pulse when WIDTH shift/rotate operations complete

## Operation
- State: q (WIDTH flops), cnt (clog2(WIDTH+1) bits), word_done flop.
- Modes, applied on a rising clk edge when en=1:
  - 000 hold: q unchanged.
  - 001 load: q <= d.
  - 010 shift left: q <= {q[WIDTH-2:0], sin_lsb}.
  - 011 shift right: q <= {sin_msb, q[WIDTH-1:1]}.
  - 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 110 clear: q <= 0.
  - 111 complement: q <= ~q.
- en=0: every mode behaves as hold. cnt holds and word_done <= 0.
- Counter rules (en=1):
  - Shift or rotate modes (010-101): if cnt==WIDTH-1, then cnt <= 0 and word_done <= 1; otherwise cnt <= cnt+1 and word_done <= 0.
  - Load or clear: cnt <= 0 and word_done <= 0.
  - Hold or complement: cnt holds and word_done <= 0.
- Direction changes between shift/rotate modes do not reset cnt. Any mix of WIDTH shift/rotate operations counts as one word.
- Reset, asynchronous and effective immediately with no clock edge needed: q = RESET_VAL, q_bar = ~RESET_VAL, cnt = 0, word_done = 0, so_msb/so_lsb follow q.
- Reset asserted mid-count: count is discarded. After release, the first word_done requires WIDTH fresh shift/rotate operations.
- All mode values are decoded; there is no illegal encoding.

## Timing
- Latency: q updates on the same rising edge that samples en/mode/d/sin_*. It is visible one cycle after the inputs are presented.
- word_done is high for exactly the cycle following the edge that performs the WIDTH-th shift/rotate. That is the same edge on which q holds the completed word. It is never high two cycles in a row unless another full WIDTH-operation word completes, which requires WIDTH ≥ 1 further operations; with WIDTH ≥ 2, pulses are at least WIDTH cycles apart.
- q_bar, so_msb and so_lsb are combinational from q; they add no extra cycle.
- Reset deassertion is synchronised externally. The block assumes rst releases at least setup time before a clk edge.

## Test plan
- Reset: with q=0x5A, assert rst between clock edges. Required: q=0x00, q_bar=0xFF, word_done=0 before the next edge. Repeat with RESET_VAL=0x81: q=0x81.
- Load then shift: load d=0xA5, then shift left with sin_lsb=1. Required: q=0x4B, so_msb=0. Then shift right with sin_msb=1. Required: q=0xA5.
- Rotate word: load 0x81, then rotate right for 8 cycles. Required after the first rotate: q=0xC0. After the 8th: q=0x81, with word_done high exactly one cycle following the 8th edge and low otherwise.
- Enable gating: load 0x3C, hold en=0 with mode=010 for 4 cycles. Required: q stays 0x3C and cnt is unchanged. Then en=1 with complement. Required: q=0xC3. Then clear. Required: q=0x00.
- Count restart: perform 5 shifts, then load 0xFF, then perform 8 shifts. Required: no word_done after the 5 shifts or the load; word_done pulses once after the 8th post-load shift.
- Reset mid-count: perform 6 shifts, pulse rst, then perform 8 shifts. Required: word_done only after the 8th post-reset shift, and never at post-reset shift 2.

Source files
------------

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module   : univ_shift_reg
// Brief    : WIDTH-bit universal register (hold/load/shift/rotate/clear/
//            complement) with a word-completion counter for serial transfers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             word_done
);

    localparam int C_CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] C_MODE_HOLD  = 3'b000;
    localparam logic [2:0] C_MODE_LOAD  = 3'b001;
    localparam logic [2:0] C_MODE_SHL   = 3'b010;
    localparam logic [2:0] C_MODE_SHR   = 3'b011;
    localparam logic [2:0] C_MODE_ROL   = 3'b100;
    localparam logic [2:0] C_MODE_ROR   = 3'b101;
    localparam logic [2:0] C_MODE_CLEAR = 3'b110;
    localparam logic [2:0] C_MODE_COMPL = 3'b111;

    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    logic [WIDTH-1:0]   r_q;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_word_done;

    logic [WIDTH-1:0]   w_q_next;
    logic [C_CNT_W-1:0] w_cnt_next;
    logic               w_done_next;
    logic               w_is_serial;

    // Data path: next register value for the selected mode
    always_comb begin
        w_q_next = r_q;
        if (en) begin
            case (mode)
                C_MODE_HOLD:  w_q_next = r_q;
                C_MODE_LOAD:  w_q_next = d;
                C_MODE_SHL:   w_q_next = {r_q[WIDTH-2:0], sin_lsb};
                C_MODE_SHR:   w_q_next = {sin_msb, r_q[WIDTH-1:1]};
                C_MODE_ROL:   w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                C_MODE_ROR:   w_q_next = {r_q[0], r_q[WIDTH-1:1]};
                C_MODE_CLEAR: w_q_next = '0;
                C_MODE_COMPL: w_q_next = ~r_q;
                default:      w_q_next = r_q;
            endcase
        end
    end

    // Any of the four shift/rotate modes advances the word counter
    assign w_is_serial = (mode == C_MODE_SHL) || (mode == C_MODE_SHR) ||
                         (mode == C_MODE_ROL) || (mode == C_MODE_ROR);

    always_comb begin
        w_cnt_next  = r_cnt;
        w_done_next = 1'b0;
        if (en) begin
            if (w_is_serial) begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_next  = '0;
                    w_done_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + C_CNT_ONE;
                end
            end else if ((mode == C_MODE_LOAD) || (mode == C_MODE_CLEAR)) begin
                w_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= RESET_VAL;
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_q         <= w_q_next;
            r_cnt       <= w_cnt_next;
            r_word_done <= w_done_next;
        end
    end

    assign q         = r_q;
    assign q_bar     = ~r_q;
    assign so_msb    = r_q[WIDTH-1];
    assign so_lsb    = r_q[0];
    assign word_done = r_word_done;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: directed scenarios plus randomized
// traffic checked against an arithmetic reference model.
`default_nettype none

module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst2 = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] d = 8'h00;
    logic       sin_lsb = 1'b0;
    logic       sin_msb = 1'b0;
    logic [7:0] q, q_bar, q2, q_bar2;
    logic       so_msb, so_lsb, word_done;
    logic       so_msb2, so_lsb2, word_done2;

    int checks = 0;
    int failures = 0;

    int mq = 0;
    int mops = 0;
    int mwd = 0;

    int exp_q[$];
    int exp_wd[$];

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_lsb(sin_lsb), .sin_msb(sin_msb),
        .q(q), .q_bar(q_bar), .so_msb(so_msb), .so_lsb(so_lsb),
        .word_done(word_done)
    );

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h81)) dut2 (
        .clk(clk), .rst(rst2), .en(en), .mode(mode), .d(d),
        .sin_lsb(sin_lsb), .sin_msb(sin_msb),
        .q(q2), .q_bar(q_bar2), .so_msb(so_msb2), .so_lsb(so_lsb2),
        .word_done(word_done2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register as an integer 0..255, transfers counted as ops
    task automatic model_apply(input logic e, input logic [2:0] m, input int dd,
                               input int sl, input int sr);
        mwd = 0;
        if (!e) return;
        case (m)
            3'd1: begin mq = dd; mops = 0; end
            3'd2: mq = (mq * 2 + sl) % 256;
            3'd3: mq = mq / 2 + sr * 128;
            3'd4: mq = (mq * 2) % 256 + mq / 128;
            3'd5: mq = mq / 2 + (mq % 2) * 128;
            3'd6: begin mq = 0; mops = 0; end
            3'd7: mq = 255 - mq;
            default: ;
        endcase
        if (m >= 3'd2 && m <= 3'd5) begin
            mops++;
            if (mops == 8) begin
                mwd = 1;
                mops = 0;
            end
        end
    endtask

    task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dd,
                        input logic sl, input logic sr);
        @(negedge clk);
        en = e; mode = m; d = dd; sin_lsb = sl; sin_msb = sr;
        model_apply(e, m, int'(dd), int'(sl), int'(sr));
        exp_q.push_back(mq);
        exp_wd.push_back(mwd);
        @(posedge clk);
    endtask

    // Reset pulsed between edges; outputs must follow without a clock edge
    task automatic pulse_reset();
        @(negedge clk);
        en = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_q", 64'(q), 64'h00);
        chk("rst_q_bar", 64'(q_bar), 64'hFF);
        chk("rst_word_done", 64'(word_done), 64'h0);
        chk("rst_so", 64'({so_msb, so_lsb}), 64'h0);
        #1 rst = 1'b0;
        mq = 0; mops = 0; mwd = 0;
        exp_q.push_back(mq);
        exp_wd.push_back(mwd);
        @(posedge clk);
    endtask

    // Monitor: one registered result per cycle that the driver announced
    initial begin
        int eq, ew;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                eq = exp_q.pop_front();
                ew = exp_wd.pop_front();
                chk("q", 64'(q), 64'(eq));
                chk("q_bar", 64'(q_bar), 64'(255 - eq));
                chk("so_msb", 64'(so_msb), 64'(eq / 128));
                chk("so_lsb", 64'(so_lsb), 64'(eq % 2));
                chk("word_done", 64'(word_done), 64'(ew));
            end
        end
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        #12;
        chk("init_q", 64'(q), 64'h00);
        chk("init_q2", 64'(q2), 64'h81);
        rst = 1'b0; rst2 = 1'b0;

        // Reset from a non-zero value, both reset values
        step(1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst2 = 1'b1;
        #1;
        chk("rst2_q", 64'(q2), 64'h81);
        chk("rst2_q_bar", 64'(q_bar2), 64'h7E);
        chk("rst2_word_done", 64'(word_done2), 64'h0);
        #1 rst2 = 1'b0;
        pulse_reset();

        // Load then shift left / right
        step(1'b1, 3'd1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        step(1'b1, 3'd3, 8'h00, 1'b0, 1'b1);

        // Full rotate-right word
        step(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
        step(1'b1, 3'd0, 8'h00, 1'b0, 1'b0);

        // Enable gating, complement, clear; then a word to prove cnt held
        step(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 3'd2, 8'hFF, 1'b1, 1'b1);
        step(1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        step(1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);

        // Count restart by load
        for (int i = 0; i < 5; i++) step(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        step(1'b1, 3'd1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);

        // Reset mid-count
        for (int i = 0; i < 6; i++) step(1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
        pulse_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);

        // Randomized traffic, serial modes weighted up
        for (int i = 0; i < 400; i++) begin
            logic       e;
            logic [2:0] m;
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset();
            end else begin
                e = ($urandom_range(0, 9) < 8);
                m = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7))
                                                : 3'($urandom_range(2, 5));
                step(e, m, 8'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
